// File: rtl/idu_pkg.sv
// Shared decode-stage types: opcode map, operand selects, control word and the
// decoded bundle carried through the FIFO (pc/imm held at the widest XLEN).
package idu_pkg;

    localparam int XLEN_MAX = 64;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    typedef enum logic [1:0] {
        OP1_ZERO = 2'd0,
        OP1_PC   = 2'd1,
        OP1_RS1  = 2'd2
    } sel_op1_e;

    typedef enum logic [1:0] {
        OP2_RS2 = 2'd0,
        OP2_IMM = 2'd1
    } sel_op2_e;

    typedef struct packed {
        logic reg_write;
        logic pc_write;
        logic mem_read;
        logic mem_write;
        logic is_csr;
        logic is_ecall;
        logic is_mret;
        logic is_ebreak;
        logic jump;
        logic branch;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN_MAX-1:0] pc;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [XLEN_MAX-1:0] imm;
        logic [6:0]          opcode;
        logic [2:0]          func3;
        logic [6:0]          func7;
        sel_op1_e            sel_op1;
        sel_op2_e            sel_op2;
        ctrl_t               ctrl;
        logic [2:0]          csr_waddr;
        logic                illegal;
    } dec_bundle_t;

    function automatic logic reg_ok(input logic [4:0] idx, input int nr);
        return {27'd0, idx} < 32'(nr);
    endfunction

endpackage

// File: rtl/idu_decoder.sv
// Combinational RV32 decoder: raw instruction -> dec_bundle_t, zero latency,
// no handshake. Immediates are sign-extended to 64 bits; the caller truncates.
module idu_decoder import idu_pkg::*; #(
    parameter int NR_REG = 32
) (
    input  logic [31:0]         inst,
    input  logic [XLEN_MAX-1:0] pc,
    output dec_bundle_t         dec
);

    logic [XLEN_MAX-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic       use_rd, use_rs1, use_rs2, op_ok, illegal;
    ctrl_t      c;

    assign opcode = inst[6:0];
    assign func3  = inst[14:12];
    assign imm_i  = {{52{inst[31]}}, inst[31:20]};
    assign imm_s  = {{52{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u  = {{32{inst[31]}}, inst[31:12], 12'd0};
    assign imm_j  = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        dec       = '0;
        c         = '0;
        use_rd    = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        op_ok     = 1'b1;
        dec.pc        = pc;
        dec.rs1       = inst[19:15];
        dec.rs2       = inst[24:20];
        dec.rd        = inst[11:7];
        dec.opcode    = opcode;
        dec.func3     = func3;
        dec.func7     = inst[31:25];
        dec.csr_waddr = inst[22:20];
        dec.sel_op1   = OP1_ZERO;
        dec.sel_op2   = OP2_RS2;
        case (opcode)
            OP_LUI: begin
                dec.imm = imm_u; dec.sel_op2 = OP2_IMM;
                c.reg_write = 1'b1; use_rd = 1'b1;
            end
            OP_AUIPC: begin
                dec.imm = imm_u; dec.sel_op1 = OP1_PC; dec.sel_op2 = OP2_IMM;
                c.reg_write = 1'b1; use_rd = 1'b1;
            end
            OP_JAL: begin
                dec.imm = imm_j; dec.sel_op1 = OP1_PC; dec.sel_op2 = OP2_IMM;
                c.reg_write = 1'b1; c.jump = 1'b1; use_rd = 1'b1;
            end
            OP_JALR: begin
                dec.imm = imm_i; dec.sel_op1 = OP1_RS1; dec.sel_op2 = OP2_IMM;
                c.reg_write = 1'b1; c.jump = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1;
            end
            OP_BRANCH: begin
                dec.imm = imm_b; dec.sel_op1 = OP1_RS1;
                c.branch = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OP_LOAD: begin
                dec.imm = imm_i; dec.sel_op1 = OP1_RS1; dec.sel_op2 = OP2_IMM;
                c.reg_write = 1'b1; c.mem_read = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1;
            end
            OP_STORE: begin
                dec.imm = imm_s; dec.sel_op1 = OP1_RS1; dec.sel_op2 = OP2_IMM;
                c.mem_write = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OP_IMM: begin
                dec.imm = imm_i; dec.sel_op1 = OP1_RS1; dec.sel_op2 = OP2_IMM;
                c.reg_write = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1;
            end
            OP_OP: begin
                dec.sel_op1 = OP1_RS1;
                c.reg_write = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OP_SYSTEM: begin
                dec.sel_op1 = OP1_RS1;
                c.is_ecall  = (inst == INST_ECALL);
                c.is_ebreak = (inst == INST_EBREAK);
                c.is_mret   = (inst == INST_MRET);
                if (func3 != 3'd0) begin
                    // func3[2] set means the rs1 field is a zimm, not a register
                    c.is_csr = 1'b1; c.reg_write = 1'b1;
                    use_rd = 1'b1; use_rs1 = ~func3[2];
                end
            end
            default: op_ok = 1'b0;
        endcase

        illegal = (inst[1:0] != 2'b11) | ~op_ok
                | (use_rd  & ~reg_ok(inst[11:7],  NR_REG))
                | (use_rs1 & ~reg_ok(inst[19:15], NR_REG))
                | (use_rs2 & ~reg_ok(inst[24:20], NR_REG));

        if (inst[11:7] == 5'd0) c.reg_write = 1'b0;
        if (illegal) begin
            c.reg_write = 1'b0;
            c.mem_read  = 1'b0;
            c.mem_write = 1'b0;
        end
        c.pc_write  = (c.jump | c.branch) & ~illegal;
        dec.ctrl    = c;
        dec.illegal = illegal;
    end

endmodule

// File: rtl/idu_pipe.sv
// Decode stage: decodes on accept, buffers bundles in a DEPTH-entry FIFO; 1-cycle latency to head.
// in_ready drops when full (no bypass), flushing or in reset. IDU_PERF_EN adds perf counters.
module idu_pipe import idu_pkg::*; #(
    parameter int XLEN   = 32,
    parameter int NR_REG = 32,
    parameter int DEPTH  = 2
) (
    input  logic            clk,
    input  logic            rst,
`ifdef IDU_PERF_EN
    output logic [31:0]     perf_decoded,
    output logic [31:0]     perf_illegal,
`endif
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_func3,
    output logic [6:0]      out_func7,
    output logic [1:0]      out_sel_op1,
    output logic [1:0]      out_sel_op2,
    output logic [9:0]      out_ctrl,
    output logic [2:0]      out_csr_waddr,
    output logic            out_illegal
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    dec_bundle_t dec, head, out_b;
    dec_bundle_t mem_q [DEPTH];
    dec_bundle_t mem_d [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic in_fire, out_fire;
    logic unused_bits;

    idu_decoder #(.NR_REG(NR_REG)) u_dec (
        .inst (in_inst),
        .pc   (XLEN_MAX'(in_pc)),
        .dec  (dec)
    );

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign in_ready  = ~rst & ~flush & (count_q < CW'(DEPTH));
    assign out_valid = ~rst & (count_q != '0);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (in_fire) begin
                mem_d[wr_ptr_q] = dec;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (out_fire) rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({in_fire, out_fire})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Payload needs no reset: nothing leaves the FIFO unless count_q says it is valid
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign out_b = out_valid ? head : '0;

    assign out_pc        = out_b.pc[XLEN-1:0];
    assign out_rs1       = out_b.rs1;
    assign out_rs2       = out_b.rs2;
    assign out_rd        = out_b.rd;
    assign out_imm       = out_b.imm[XLEN-1:0];
    assign out_opcode    = out_b.opcode;
    assign out_func3     = out_b.func3;
    assign out_func7     = out_b.func7;
    assign out_sel_op1   = out_b.sel_op1;
    assign out_sel_op2   = out_b.sel_op2;
    assign out_ctrl      = out_b.ctrl;
    assign out_csr_waddr = out_b.csr_waddr;
    assign out_illegal   = out_b.illegal;

    // Upper pc/imm halves are dead when XLEN < 64
    assign unused_bits = ^{out_b.pc, out_b.imm};

`ifdef IDU_PERF_EN
    logic [31:0] perf_decoded_q, perf_decoded_d, perf_illegal_q, perf_illegal_d;

    always_comb begin
        perf_decoded_d = perf_decoded_q + {31'd0, in_fire};
        perf_illegal_d = perf_illegal_q + {31'd0, in_fire & dec.illegal};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_decoded_q <= '0;
            perf_illegal_q <= '0;
        end else begin
            perf_decoded_q <= perf_decoded_d;
            perf_illegal_q <= perf_illegal_d;
        end
    end

    assign perf_decoded = perf_decoded_q;
    assign perf_illegal = perf_illegal_q;
`endif

endmodule

// File: tb/tb_idu_pipe.sv
// Bench for idu_pipe: table-driven decode vectors through a scoreboard plus
// hand sequences for back-pressure, flush, reset and the RV32E / XLEN=64 build.
module tb_idu_pipe;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [1:0]  s1;
        logic [1:0]  s2;
        logic [9:0]  ctrl;
        logic [2:0]  csr;
        logic        ill;
    } obs_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] imm;
        logic [1:0]  s1;
        logic [1:0]  s2;
        logic [9:0]  ctrl;
        logic        ill;
    } vec_t;

    localparam int NV = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, flush, out_ready;
    logic [31:0] in_inst, in_pc;
    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_pc, out_imm;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [6:0]  out_opcode, out_func7;
    logic [2:0]  out_func3, out_csr_waddr;
    logic [1:0]  out_sel_op1, out_sel_op2;
    logic [9:0]  out_ctrl;

    logic        e_in_valid, e_out_ready, e_flush;
    logic [31:0] e_in_inst;
    logic [63:0] e_in_pc;
    logic        e_in_ready, e_out_valid, e_out_illegal;
    logic [63:0] e_out_pc, e_out_imm;
    logic [4:0]  e_out_rs1, e_out_rs2, e_out_rd;
    logic [6:0]  e_out_opcode, e_out_func7;
    logic [2:0]  e_out_func3, e_out_csr_waddr;
    logic [1:0]  e_out_sel_op1, e_out_sel_op2;
    logic [9:0]  e_out_ctrl;
`ifdef IDU_PERF_EN
    logic [31:0] perf_decoded, perf_illegal, e_perf_decoded, e_perf_illegal;
`endif

    idu_pipe #(.XLEN(32), .NR_REG(32), .DEPTH(2)) u_dut (
        .clk(clk), .rst(rst),
`ifdef IDU_PERF_EN
        .perf_decoded(perf_decoded), .perf_illegal(perf_illegal),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_imm(out_imm), .out_opcode(out_opcode), .out_func3(out_func3),
        .out_func7(out_func7), .out_sel_op1(out_sel_op1), .out_sel_op2(out_sel_op2),
        .out_ctrl(out_ctrl), .out_csr_waddr(out_csr_waddr), .out_illegal(out_illegal)
    );

    idu_pipe #(.XLEN(64), .NR_REG(16), .DEPTH(2)) u_dut_e (
        .clk(clk), .rst(rst),
`ifdef IDU_PERF_EN
        .perf_decoded(e_perf_decoded), .perf_illegal(e_perf_illegal),
`endif
        .in_valid(e_in_valid), .in_ready(e_in_ready), .in_inst(e_in_inst), .in_pc(e_in_pc),
        .flush(e_flush), .out_valid(e_out_valid), .out_ready(e_out_ready),
        .out_pc(e_out_pc), .out_rs1(e_out_rs1), .out_rs2(e_out_rs2), .out_rd(e_out_rd),
        .out_imm(e_out_imm), .out_opcode(e_out_opcode), .out_func3(e_out_func3),
        .out_func7(e_out_func7), .out_sel_op1(e_out_sel_op1), .out_sel_op2(e_out_sel_op2),
        .out_ctrl(e_out_ctrl), .out_csr_waddr(e_out_csr_waddr), .out_illegal(e_out_illegal)
    );

    obs_t obs, cur_exp, popped;
    assign obs = {out_pc, out_rs1, out_rs2, out_rd, out_imm, out_opcode, out_func3,
                  out_func7, out_sel_op1, out_sel_op2, out_ctrl, out_csr_waddr, out_illegal};

    vec_t vecs [NV];
    obs_t sb [$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic obs_t mk_exp(input vec_t v, input logic [31:0] pc);
        obs_t        e;
        logic [31:0] w;
        w      = v.inst;
        e.pc   = pc;
        e.rs1  = w[19:15];
        e.rs2  = w[24:20];
        e.rd   = w[11:7];
        e.imm  = v.imm;
        e.opc  = w[6:0];
        e.f3   = w[14:12];
        e.f7   = w[31:25];
        e.s1   = v.s1;
        e.s2   = v.s2;
        e.ctrl = v.ctrl;
        e.csr  = w[22:20];
        e.ill  = v.ill;
        return e;
    endfunction

    // Scoreboard: pop before push, since a bundle accepted this cycle cannot be the head
    always @(negedge clk) begin
        if (rst || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                chk("sb_nonempty", (sb.size() != 0), 1'b1);
                if (sb.size() != 0) begin
                    popped = sb.pop_front();
                    chk("sb_bundle", obs, popped);
                end
            end
            if (in_valid && in_ready) sb.push_back(cur_exp);
        end
    end

    task automatic set_in(input int idx, input logic [31:0] pc);
        in_inst = vecs[idx].inst;
        in_pc   = pc;
        cur_exp = mk_exp(vecs[idx], pc);
    endtask

    task automatic push(input int idx, input logic [31:0] pc);
        logic ok;
        ok = 1'b0;
        set_in(idx, pc);
        in_valid = 1'b1;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            if (!ok) begin
                @(posedge clk);
                #1;
            end
        end
        chk("push_accept", ok, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 50 && sb.size() != 0; k++) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0; cur_exp = '0;
        e_in_valid = 1'b0; e_out_ready = 1'b0; e_flush = 1'b0; e_in_inst = '0; e_in_pc = '0;

        //            inst          imm           s1    s2    ctrl     ill
        vecs[0]  = '{32'h00500093, 32'h00000005, 2'd2, 2'd1, 10'h200, 1'b0}; // addi x1,x0,5
        vecs[1]  = '{32'h00001037, 32'h00001000, 2'd0, 2'd1, 10'h000, 1'b0}; // lui x0,1
        vecs[2]  = '{32'h800000B7, 32'h80000000, 2'd0, 2'd1, 10'h200, 1'b0}; // lui x1,0x80000
        vecs[3]  = '{32'h00100073, 32'h00000000, 2'd2, 2'd0, 10'h004, 1'b0}; // ebreak
        vecs[4]  = '{32'h00000073, 32'h00000000, 2'd2, 2'd0, 10'h010, 1'b0}; // ecall
        vecs[5]  = '{32'h30200073, 32'h00000000, 2'd2, 2'd0, 10'h008, 1'b0}; // mret
        vecs[6]  = '{32'h011000B3, 32'h00000000, 2'd2, 2'd0, 10'h200, 1'b0}; // add x1,x0,x17
        vecs[7]  = '{32'h008000EF, 32'h00000008, 2'd1, 2'd1, 10'h302, 1'b0}; // jal x1,8
        vecs[8]  = '{32'hFE208EE3, 32'hFFFFFFFC, 2'd2, 2'd0, 10'h101, 1'b0}; // beq x1,x2,-4
        vecs[9]  = '{32'hFF812283, 32'hFFFFFFF8, 2'd2, 2'd1, 10'h280, 1'b0}; // lw x5,-8(x2)
        vecs[10] = '{32'h00312623, 32'h0000000C, 2'd2, 2'd1, 10'h040, 1'b0}; // sw x3,12(x2)
        vecs[11] = '{32'h12345197, 32'h12345000, 2'd1, 2'd1, 10'h200, 1'b0}; // auipc x3,0x12345
        vecs[12] = '{32'h00000000, 32'h00000000, 2'd0, 2'd0, 10'h000, 1'b1}; // inst[1:0] != 11
        vecs[13] = '{32'h0000007F, 32'h00000000, 2'd0, 2'd0, 10'h000, 1'b1}; // unknown opcode
        vecs[14] = '{32'h305312F3, 32'h00000000, 2'd2, 2'd0, 10'h220, 1'b0}; // csrrw x5,mtvec,x6

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_idle_zero", obs, '0);
`ifdef IDU_PERF_EN
        chk("reset_perf_decoded", perf_decoded, 32'd0);
`endif

        // Decode table, back-to-back with the consumer always ready
        out_ready = 1'b1;
        step();
        push(0, 32'h1000);
        @(negedge clk);
        chk("first_latency", out_valid, 1'b1);
        step();
        for (int i = 1; i < NV; i++) push(i, 32'h1000 + 32'(4 * i));
        drain();

        // Back-pressure: two accepts fill DEPTH=2, no same-cycle bypass on the first pop
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_in(0, 32'h2000);
        @(negedge clk); chk("bp_accept0", in_ready, 1'b1); step();
        set_in(6, 32'h2004);
        @(negedge clk); chk("bp_accept1", in_ready, 1'b1); step();
        set_in(11, 32'h2008);
        @(negedge clk); chk("bp_full_ready", in_ready, 1'b0); chk("bp_full_valid", out_valid, 1'b1);
        step();
        @(negedge clk); chk("bp_still_full", in_ready, 1'b0); step();
        out_ready = 1'b1;
        @(negedge clk); chk("bp_no_bypass", in_ready, 1'b0); step();
        @(negedge clk); chk("bp_third_accept", in_ready, 1'b1); step();
        in_valid = 1'b0;
        drain();

        // Flush with two buffered entries and a competing push
        out_ready = 1'b0;
        push(1, 32'h3000);
        push(2, 32'h3004);
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        set_in(9, 32'h3008);
        @(negedge clk); chk("flush_blocks_in", in_ready, 1'b0);
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_idle_zero", obs, '0);
        chk("flush_ready_after", in_ready, 1'b1);
        step();
        out_ready = 1'b1;
        push(10, 32'h3010);
        drain();

        // Reset mid-operation with two entries buffered and the consumer ready
        out_ready = 1'b0;
        push(3, 32'h4000);
        push(4, 32'h4004);
        rst = 1'b1; out_ready = 1'b1;
        @(negedge clk); chk("rst_no_out_fire", out_valid, 1'b0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_out_valid", out_valid, 1'b0);
        chk("rst_mid_in_ready", in_ready, 1'b1);
`ifdef IDU_PERF_EN
        chk("perf_decoded_cleared", perf_decoded, 32'd0);
        chk("perf_illegal_cleared", perf_illegal, 32'd0);
`endif
        step();
        push(0, 32'h5000);
        push(12, 32'h5004);
        push(6, 32'h5008);
`ifdef IDU_PERF_EN
        @(negedge clk);
        chk("perf_decoded_3", perf_decoded, 32'd3);
        chk("perf_illegal_1", perf_illegal, 32'd1);
        step();
`endif
        drain();

        // RV32E, XLEN=64 instance: x17 is out of range; U-immediate sign-extends to 64 bits
        e_out_ready = 1'b1;
        e_in_valid  = 1'b1;
        e_in_inst   = 32'h011000B3;
        e_in_pc     = 64'h8000_0000_0000_0000;
        @(negedge clk); chk("e_in_ready", e_in_ready, 1'b1);
        step();
        e_in_inst = 32'h800000B7;
        e_in_pc   = 64'h8000_0000_0000_0004;
        @(negedge clk);
        chk("e_add_valid", e_out_valid, 1'b1);
        chk("e_add_illegal", e_out_illegal, 1'b1);
        chk("e_add_reg_write", e_out_ctrl[9], 1'b0);
        chk("e_add_pc", e_out_pc, 64'h8000_0000_0000_0000);
        step();
        e_in_valid = 1'b0;
        @(negedge clk);
        chk("e_lui_valid", e_out_valid, 1'b1);
        chk("e_lui_imm", e_out_imm, 64'hFFFF_FFFF_8000_0000);
        chk("e_lui_legal", e_out_illegal, 1'b0);
        chk("e_lui_reg_write", e_out_ctrl[9], 1'b1);
        step();
        @(negedge clk);
        chk("e_empty", e_out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
